// File: rtl/clk_meas_seq.sv
// Measurement sequencer: issues 2^log2n measurement commands, accumulates the
// returned counts and reports average/min/max, with a dead-clock timeout and abort.
module clk_meas_seq #(
  parameter int                   TIMEOUT_W = 28,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 28'h8000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] ctl_len,
  input  logic [2:0]  ctl_log2n,
  input  logic        ctl_cont,
  input  logic        ctl_start,
  input  logic        ctl_abort,
  output logic [23:0] meas_cmd_len,
  output logic        meas_cmd_stb,
  input  logic [31:0] meas_resp_cnt,
  input  logic        meas_resp_stb,
  output logic [31:0] res_avg,
  output logic [31:0] res_min,
  output logic [31:0] res_max,
  output logic        res_timeout,
  output logic        res_stb,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_DONE} state_t;

  localparam logic [TIMEOUT_W-1:0] TMR_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [23:0]          len_q, len_d;
  logic [2:0]           log2n_q, log2n_d;
  logic                 cont_q, cont_d;
  logic [7:0]           run_q, run_d;
  logic [38:0]          sum_q, sum_d;
  logic [31:0]          min_q, min_d, max_q, max_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic [31:0]          avg_q, avg_d, rmin_q, rmin_d, rmax_q, rmax_d;
  logic                 to_q, to_d, stb_q, stb_d;

  logic [7:0]  run_inc, run_target;
  logic [38:0] sum_acc, sum_shift;
  logic [31:0] min_acc, max_acc;
  logic        expired;

  always_comb begin
    run_inc    = run_q + 8'd1;
    run_target = 8'd1 << log2n_q;
    sum_acc    = sum_q + {7'd0, meas_resp_cnt};
    sum_shift  = sum_acc >> log2n_q;
    min_acc    = (meas_resp_cnt < min_q) ? meas_resp_cnt : min_q;
    max_acc    = (meas_resp_cnt > max_q) ? meas_resp_cnt : max_q;
    // Expiry is flagged on the last counted cycle so the response still wins a tie.
    expired    = (timer_q <= TMR_ONE);
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    log2n_d = log2n_q;
    cont_d  = cont_q;
    run_d   = run_q;
    sum_d   = sum_q;
    min_d   = min_q;
    max_d   = max_q;
    timer_d = timer_q;
    avg_d   = avg_q;
    rmin_d  = rmin_q;
    rmax_d  = rmax_q;
    to_d    = to_q;
    stb_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ctl_start) begin
          len_d   = ctl_len;
          log2n_d = ctl_log2n;
          cont_d  = ctl_cont;
          run_d   = 8'd0;
          sum_d   = 39'd0;
          min_d   = 32'hFFFF_FFFF;
          max_d   = 32'd0;
          to_d    = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = TIMEOUT;
        state_d = ctl_abort ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (timer_q != '0) timer_d = timer_q - TMR_ONE;
        if (meas_resp_stb) begin
          sum_d = sum_acc;
          min_d = min_acc;
          max_d = max_acc;
          run_d = run_inc;
          if (ctl_abort) begin
            // The outstanding response has just arrived, so nothing is left to drain.
            state_d = S_IDLE;
          end else if (run_inc == run_target) begin
            avg_d   = sum_shift[31:0];
            rmin_d  = min_acc;
            rmax_d  = max_acc;
            stb_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end else if (ctl_abort) begin
          state_d = S_DRAIN;
        end else if (expired) begin
          to_d    = 1'b1;
          stb_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DRAIN: begin
        if (timer_q != '0) timer_d = timer_q - TMR_ONE;
        if (meas_resp_stb || expired) state_d = S_IDLE;
      end
      S_DONE: begin
        if (!ctl_abort && cont_q && !to_q) begin
          run_d   = 8'd0;
          sum_d   = 39'd0;
          min_d   = 32'hFFFF_FFFF;
          max_d   = 32'd0;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= 24'd0;
      log2n_q <= 3'd0;
      cont_q  <= 1'b0;
      run_q   <= 8'd0;
      sum_q   <= 39'd0;
      min_q   <= 32'hFFFF_FFFF;
      max_q   <= 32'd0;
      timer_q <= '0;
      avg_q   <= 32'd0;
      rmin_q  <= 32'hFFFF_FFFF;
      rmax_q  <= 32'd0;
      to_q    <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      log2n_q <= log2n_d;
      cont_q  <= cont_d;
      run_q   <= run_d;
      sum_q   <= sum_d;
      min_q   <= min_d;
      max_q   <= max_d;
      timer_q <= timer_d;
      avg_q   <= avg_d;
      rmin_q  <= rmin_d;
      rmax_q  <= rmax_d;
      to_q    <= to_d;
      stb_q   <= stb_d;
    end
  end

  // An abort in ISSUE suppresses the command so no response is left in flight.
  assign meas_cmd_stb = (state_q == S_ISSUE) && !ctl_abort;
  assign meas_cmd_len = len_q;
  assign res_avg      = avg_q;
  assign res_min      = rmin_q;
  assign res_max      = rmax_q;
  assign res_timeout  = to_q;
  assign res_stb      = stb_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_clk_meas_seq.sv
// Directed and randomized bench for clk_meas_seq with a responder and a
// queue-based arithmetic reference model of the expected results.
module tb_clk_meas_seq;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] ctl_len;
  logic [2:0]  ctl_log2n;
  logic        ctl_cont, ctl_start, ctl_abort;
  logic [23:0] meas_cmd_len;
  logic        meas_cmd_stb;
  logic [31:0] meas_resp_cnt;
  logic        meas_resp_stb;
  logic [31:0] res_avg, res_min, res_max;
  logic        res_timeout, res_stb, busy;

  clk_meas_seq #(.TIMEOUT_W(28), .TIMEOUT(28'd64)) dut (
    .clk(clk), .rst_n(rst_n),
    .ctl_len(ctl_len), .ctl_log2n(ctl_log2n), .ctl_cont(ctl_cont),
    .ctl_start(ctl_start), .ctl_abort(ctl_abort),
    .meas_cmd_len(meas_cmd_len), .meas_cmd_stb(meas_cmd_stb),
    .meas_resp_cnt(meas_resp_cnt), .meas_resp_stb(meas_resp_stb),
    .res_avg(res_avg), .res_min(res_min), .res_max(res_max),
    .res_timeout(res_timeout), .res_stb(res_stb), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [23:0] len; } cmd_t;
  typedef struct { int cyc; logic [31:0] avg; logic [31:0] mn; logic [31:0] mx; logic to; } res_t;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  cmd_t cmd_q[$];
  res_t res_q[$];
  logic [31:0] vals[$];
  int          dlys[$];
  logic [31:0] exp_avg = 32'd0, exp_min = 32'hFFFF_FFFF, exp_max = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (meas_cmd_stb) cmd_q.push_back('{cyc, meas_cmd_len});
    if (res_stb) res_q.push_back('{cyc, res_avg, res_min, res_max, res_timeout});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input int lg, input logic [23:0] len, input logic cont);
    @(negedge clk);
    ctl_len   = len;
    ctl_log2n = 3'(lg);
    ctl_cont  = cont;
    ctl_start = 1'b1;
  endtask

  task automatic get_cmd(output int t, output logic [23:0] l);
    int   n;
    cmd_t c;
    n = 0; t = -1; l = '0;
    while (cmd_q.size() == 0 && n < 2000) begin
      @(negedge clk);
      if (ctl_start) begin
        // Scramble the controls after start to prove they were latched.
        ctl_start = 1'b0;
        ctl_len   = 24'($urandom);
        ctl_log2n = 3'($urandom);
      end
      n++;
    end
    if (cmd_q.size() == 0) begin
      checks++; failures++;
      $error("FAIL cmd_wait observed=none expected=meas_cmd_stb");
    end else begin
      c = cmd_q.pop_front();
      t = c.cyc; l = c.len;
    end
  endtask

  task automatic respond(input int t_cmd, input int d, input logic [31:0] v, output int t_resp);
    while (cyc < t_cmd + d) @(negedge clk);
    meas_resp_cnt = v;
    meas_resp_stb = 1'b1;
    t_resp = cyc;
    @(negedge clk);
    meas_resp_stb = 1'b0;
    meas_resp_cnt = $urandom;
  endtask

  task automatic get_res(output res_t r);
    int n;
    n = 0;
    r = '{-1, 32'd0, 32'd0, 32'd0, 1'b0};
    while (res_q.size() == 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (res_q.size() == 0) begin
      checks++; failures++;
      $error("FAIL res_wait observed=none expected=res_stb");
    end else begin
      r = res_q.pop_front();
    end
  endtask

  // Plays one sequence of vals/dlys and checks the reported statistics.
  task automatic run_seq(input int lg, input logic [23:0] len);
    int              t, tr;
    logic [23:0]     l;
    res_t            r;
    longint unsigned sum;
    logic [31:0]     mn, mx;
    sum = 0; mn = 32'hFFFF_FFFF; mx = 32'd0; tr = 0;
    for (int i = 0; i < vals.size(); i++) begin
      get_cmd(t, l);
      if (t < 0) return;
      check("cmd_len", 64'(l), 64'(len));
      if (i > 0) check("cmd_gap", 64'(t), 64'(tr + 1));
      respond(t, dlys[i], vals[i], tr);
      sum += longint'(vals[i]);
      if (vals[i] < mn) mn = vals[i];
      if (vals[i] > mx) mx = vals[i];
    end
    exp_avg = 32'(sum >> lg);
    exp_min = mn;
    exp_max = mx;
    get_res(r);
    if (r.cyc < 0) return;
    $display("seq log2n=%0d runs=%0d avg=%0h min=%0h max=%0h to=%0b", lg, vals.size(), r.avg, r.mn, r.mx, r.to);
    check("res_latency", 64'(r.cyc), 64'(tr + 1));
    check("res_avg", 64'(r.avg), 64'(exp_avg));
    check("res_min", 64'(r.mn), 64'(exp_min));
    check("res_max", 64'(r.mx), 64'(exp_max));
    check("res_timeout", 64'(r.to), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_stb"}, 64'(meas_cmd_stb), 64'd0);
    check({tag, "_cmd_len"}, 64'(meas_cmd_len), 64'd0);
    check({tag, "_busy"},    64'(busy), 64'd0);
    check({tag, "_res_stb"}, 64'(res_stb), 64'd0);
    check({tag, "_res_to"},  64'(res_timeout), 64'd0);
    check({tag, "_res_avg"}, 64'(res_avg), 64'd0);
    check({tag, "_res_min"}, 64'(res_min), 64'hFFFF_FFFF);
    check({tag, "_res_max"}, 64'(res_max), 64'd0);
  endtask

  initial begin
    int          t, tr, lg;
    logic [23:0] l, len;
    res_t        r;

    rst_n = 1'b0; ctl_len = '0; ctl_log2n = '0; ctl_cont = 1'b0;
    ctl_start = 1'b0; ctl_abort = 1'b0; meas_resp_cnt = '0; meas_resp_stb = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single run, long response delay.
    start(0, 24'd9999, 1'b0);
    vals = '{32'd10000}; dlys = '{50};
    run_seq(0, 24'd9999);

    // Four runs, truncated average.
    start(2, 24'd500, 1'b0);
    vals = '{32'd100, 32'd103, 32'd98, 32'd101};
    dlys = '{$urandom_range(1, 10), $urandom_range(1, 10), $urandom_range(1, 10), $urandom_range(1, 10)};
    run_seq(2, 24'd500);

    // 128 all-ones responses must not wrap the sum.
    start(7, 24'h123456, 1'b0);
    vals.delete(); dlys.delete();
    for (int i = 0; i < 128; i++) begin
      vals.push_back(32'hFFFF_FFFF);
      dlys.push_back($urandom_range(1, 3));
    end
    run_seq(7, 24'h123456);

    // Dead clock: no response at all.
    start(0, 24'd42, 1'b0);
    get_cmd(t, l);
    get_res(r);
    $display("timeout cmd_cyc=%0d res_cyc=%0d to=%0b avg=%0h", t, r.cyc, r.to, r.avg);
    check("to_latency", 64'(r.cyc), 64'(t + TMO + 1));
    check("to_flag", 64'(r.to), 64'd1);
    check("to_avg_kept", 64'(r.avg), 64'(exp_avg));
    check("to_min_kept", 64'(r.mn), 64'(exp_min));
    check("to_max_kept", 64'(r.mx), 64'(exp_max));
    while (cyc < r.cyc + 1) @(negedge clk);
    check("to_idle_after", 64'(busy), 64'd0);

    // Continuous mode: two results back to back, then abort in WAIT.
    start(1, 24'd77, 1'b1);
    vals = '{32'd10, 32'd20}; dlys = '{4, 7};
    run_seq(1, 24'd77);
    vals = '{32'd30, 32'd40}; dlys = '{2, 9};
    run_seq(1, 24'd77);
    get_cmd(t, l);
    check("cont_restart_len", 64'(l), 64'd77);
    while (cyc < t + 2) @(negedge clk);
    ctl_abort = 1'b1;
    @(negedge clk);
    ctl_abort = 1'b0;
    ctl_cont  = 1'b0;
    check("drain_busy", 64'(busy), 64'd1);
    respond(t, 6, 32'd999, tr);
    while (cyc < tr + 1) @(negedge clk);
    $display("abort late_resp=999 busy=%0b", busy);
    check("drain_idle", 64'(busy), 64'd0);
    repeat (20) @(negedge clk);
    check("abort_no_res_stb", 64'(res_q.size()), 64'd0);
    check("abort_no_cmd", 64'(cmd_q.size()), 64'd0);
    check("abort_avg_kept", 64'(res_avg), 64'(exp_avg));
    check("abort_min_kept", 64'(res_min), 64'(exp_min));
    check("abort_max_kept", 64'(res_max), 64'(exp_max));

    // Response on the very cycle the timeout would expire.
    start(0, 24'd3, 1'b0);
    vals = '{32'hDEAD_BEEF}; dlys = '{TMO};
    run_seq(0, 24'd3);

    // Randomized sequences.
    for (int k = 0; k < 6; k++) begin
      lg  = $urandom_range(0, 4);
      len = 24'($urandom);
      vals.delete(); dlys.delete();
      for (int i = 0; i < (1 << lg); i++) begin
        vals.push_back($urandom);
        dlys.push_back($urandom_range(1, TMO - 1));
      end
      start(lg, len, 1'b0);
      run_seq(lg, len);
    end

    // Reset in the middle of WAIT.
    start(0, 24'd55, 1'b0);
    get_cmd(t, l);
    while (cyc < t + 3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("reset mid-wait busy=%0b cmd_stb=%0b", busy, meas_cmd_stb);
    check_reset_outputs("midreset");
    @(negedge clk);
    check("midreset_hold_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    cmd_q.delete(); res_q.delete();
    exp_avg = 32'd0; exp_min = 32'hFFFF_FFFF; exp_max = 32'd0;

    // Recovery after reset.
    start(0, 24'd5, 1'b0);
    vals = '{32'd1234}; dlys = '{3};
    run_seq(0, 24'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
